// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq_if
// Description : ID-stage instruction bus into alu_ctrl_seq and the decoded
//               ALU / mult-div sequencer outputs coming back.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if #(
  parameter int CODE_W = 4
);
  logic              valid;
  logic              flush;
  logic [2:0]        aluop;
  logic [5:0]        funct;
  logic [CODE_W-1:0] alu_code;
  logic              out_valid;
  logic              illegal;
  logic              stall;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              hilo_we;

  // Pipeline side: presents the instruction and consumes the decode results
  modport master (
    output valid, flush, aluop, funct,
    input  alu_code, out_valid, illegal, stall, md_start, md_op, md_busy, hilo_we
  );

  // Controller side
  modport slave (
    input  valid, flush, aluop, funct,
    output alu_code, out_valid, illegal, stall, md_start, md_op, md_busy, hilo_we
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : ALU control decoder with a fixed-latency mult/div sequencer.
//               Decodes aluop/funct into a registered alu_code, launches the
//               multi-cycle HI/LO datapath and stalls HI/LO users while busy.
//               Optional macro ALU_CTRL_SEQ_DIV_EN enables div/divu sequencing;
//               without it div/divu decode as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter int CODE_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_seq_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
`ifdef ALU_CTRL_SEQ_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_code;
  logic             dec_ill;
  logic             is_mul;
  logic             is_div;
  logic             is_hilo;
  logic             accept;
  logic             start;

  // Instruction decode: 4-bit ALU code plus classification of HI/LO users
  always_comb begin
    dec_code = 4'b0011;
    dec_ill  = 1'b0;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    is_hilo  = 1'b0;
    if (bus.aluop == 3'b000) begin
      case (bus.funct)
        6'b000000, 6'b000100: dec_code = 4'b0000;
        6'b000010, 6'b000110: dec_code = 4'b0001;
        6'b000011, 6'b000111: dec_code = 4'b0010;
        6'b100001, 6'b001001: dec_code = 4'b0011;
        6'b100011:            dec_code = 4'b1010;
        6'b100100:            dec_code = 4'b0101;
        6'b100101:            dec_code = 4'b0110;
        6'b100110:            dec_code = 4'b0111;
        6'b100111:            dec_code = 4'b1000;
        6'b101010:            dec_code = 4'b0100;
        6'b011000, 6'b011001: is_mul   = 1'b1;
`ifdef ALU_CTRL_SEQ_DIV_EN
        6'b011010, 6'b011011: is_div   = 1'b1;
`else
        6'b011010, 6'b011011: dec_ill  = 1'b1;
`endif
        6'b010000, 6'b010001,
        6'b010010, 6'b010011: is_hilo  = 1'b1;
        default:              dec_ill  = 1'b1;
      endcase
    end else begin
      case (bus.aluop)
        3'b001:  dec_code = 4'b0011;
        3'b010:  dec_code = 4'b0101;
        3'b011:  dec_code = 4'b0110;
        3'b100:  dec_code = 4'b0111;
        3'b101:  dec_code = 4'b0000;
        3'b110:  dec_code = 4'b0100;
        default: dec_code = 4'b1001;
      endcase
    end
  end

  // HI/LO users wait for the sequencer; everything else flows through
  assign bus.stall = bus.valid & ~bus.flush & (state != ST_IDLE)
                   & (is_mul | is_div | is_hilo);
  assign accept    = bus.valid & ~bus.flush & ~bus.stall;
  assign start     = accept & (is_mul | is_div) & (state == ST_IDLE);

  assign bus.md_busy = (state != ST_IDLE);
  assign bus.hilo_we = (state == ST_DONE);

  // EX-stage decode register; alu_code holds across bubbles
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.alu_code  <= '0;
      bus.out_valid <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (accept) begin
      bus.alu_code  <= CODE_W'(dec_code);
      bus.out_valid <= 1'b1;
      bus.illegal   <= dec_ill;
    end else begin
      bus.out_valid <= 1'b0;
      bus.illegal   <= 1'b0;
    end
  end

  // Mult/div sequencer: IDLE -> RUN (count down) -> DONE (write HI/LO)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bus.md_start <= 1'b0;
      bus.md_op    <= 2'b00;
    end else begin
      bus.md_start <= start;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            bus.md_op <= {is_div, bus.funct[0]};
`ifdef ALU_CTRL_SEQ_DIV_EN
            cnt       <= is_div ? DIV_LD : MUL_LD;
`else
            cnt       <= MUL_LD;
`endif
          end
        end
        ST_RUN: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Scoreboard bench for alu_ctrl_seq. Stimulus pushes expected
//               decode results, md_start events and hilo_we cycles; a monitor
//               pops and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int CODE_W  = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
  } dec_t;

  typedef struct packed {
    logic [1:0] op;
    int         cyc;
  } md_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  dec_t dq[$];
  md_t  mq[$];
  int   hq[$];

  alu_ctrl_seq_if #(.CODE_W(CODE_W)) bus ();

  alu_ctrl_seq #(
    .CODE_W (CODE_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [5:0] fn, input logic fl);
    bus.valid = 1'b1;
    bus.aluop = op;
    bus.funct = fn;
    bus.flush = fl;
  endtask

  task automatic idle();
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.aluop = 3'b000;
    bus.funct = 6'b000000;
  endtask

  // Monitor: every DUT output event must match the head of its queue
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (dq.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        dec_t e;
        e = dq.pop_front();
        check("alu_code", int'(bus.alu_code), int'(e.code));
        check("illegal", int'(bus.illegal), int'(e.ill));
      end
    end
    if (bus.md_start) begin
      if (mq.size() == 0) begin
        check("unexpected_md_start", 1, 0);
      end else begin
        md_t m;
        m = mq.pop_front();
        check("md_op", int'(bus.md_op), int'(m.op));
        check("md_start_cycle", cyc, m.cyc);
      end
    end
    if (bus.hilo_we) begin
      if (hq.size() == 0) begin
        check("unexpected_hilo_we", 1, 0);
      end else begin
        check("hilo_we_cycle", cyc, hq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed decode vectors: aluop, funct, expected code, expected illegal
  logic [2:0] v_op  [20] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                             3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [5:0] v_fn  [20] = '{6'b100011, 6'b111111, 6'b000000, 6'b000110, 6'b000011,
                             6'b001001, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                             6'b101010, 6'b010001, 6'b100000, 6'b111111, 6'b111111,
                             6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b111111};
  logic [3:0] v_cd  [20] = '{4'b1010, 4'b0011, 4'b0000, 4'b0001, 4'b0010,
                             4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                             4'b0100, 4'b0011, 4'b0011, 4'b0011, 4'b0101,
                             4'b0110, 4'b0111, 4'b0000, 4'b0100, 4'b1001};
  logic       v_il  [20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int c0;
    idle();
    rst = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_alu_code", int'(bus.alu_code), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_illegal", int'(bus.illegal), 0);
    check("rst_md_start", int'(bus.md_start), 0);
    check("rst_md_op", int'(bus.md_op), 0);
    check("rst_md_busy", int'(bus.md_busy), 0);
    check("rst_hilo_we", int'(bus.hilo_we), 0);
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back decode table
    for (int i = 0; i < 20; i++) begin
      present(v_op[i], v_fn[i], 1'b0);
      dq.push_back('{code: v_cd[i], ill: v_il[i]});
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    check("bubble_out_valid", int'(bus.out_valid), 0);
    check("bubble_alu_code_hold", int'(bus.alu_code), 9);
    tick();

    // mult, addu while busy, mflo stalled until the sequencer is idle
    c0 = cyc;
    present(3'd0, 6'b011000, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    mq.push_back('{op: 2'b00, cyc: c0 + 1});
    hq.push_back(c0 + 1 + MUL_LAT);
    tick();
    present(3'd0, 6'b100001, 1'b0);
    @(negedge clk);
    check("addu_busy_stall", int'(bus.stall), 0);
    check("addu_md_busy", int'(bus.md_busy), 1);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    tick();
    present(3'd0, 6'b010010, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      check("mflo_stall", int'(bus.stall), (k <= 5) ? 1 : 0);
      check("mflo_md_busy", int'(bus.md_busy), (k <= 5) ? 1 : 0);
      if (k == 6) dq.push_back('{code: 4'b0011, ill: 1'b0});
      tick();
    end
    idle();
    tick();

    // multu killed by flush in the same cycle
    present(3'd0, 6'b011001, 1'b1);
    tick();
    idle();
    @(negedge clk);
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_md_busy", int'(bus.md_busy), 0);
    tick();

    // multu runs to completion
    c0 = cyc;
    present(3'd0, 6'b011001, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    mq.push_back('{op: 2'b01, cyc: c0 + 1});
    hq.push_back(c0 + 1 + MUL_LAT);
    tick();
    idle();
    repeat (8) tick();

    // Reset in the middle of a mult abandons it
    c0 = cyc;
    present(3'd0, 6'b011000, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    mq.push_back('{op: 2'b00, cyc: c0 + 1});
    tick();
    idle();
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_before", int'(bus.md_busy), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy_after", int'(bus.md_busy), 0);
    repeat (10) tick();

`ifdef ALU_CTRL_SEQ_DIV_EN
    // div issued, reset at cycle 10 after issue: busy drops, no HI/LO write
    c0 = cyc;
    present(3'd0, 6'b011010, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    mq.push_back('{op: 2'b10, cyc: c0 + 1});
    tick();
    idle();
    repeat (9) tick();
    rst = 1'b0;
    @(negedge clk);
    check("div_busy_cycle10", int'(bus.md_busy), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("div_busy_cycle11", int'(bus.md_busy), 0);
    repeat (40) tick();
`else
    // div is illegal without the divider; divu during a mult is not stalled
    present(3'd0, 6'b011010, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b1});
    tick();
    idle();
    @(negedge clk);
    check("div_off_md_busy", int'(bus.md_busy), 0);
    tick();
    c0 = cyc;
    present(3'd0, 6'b011000, 1'b0);
    dq.push_back('{code: 4'b0011, ill: 1'b0});
    mq.push_back('{op: 2'b00, cyc: c0 + 1});
    hq.push_back(c0 + 1 + MUL_LAT);
    tick();
    present(3'd0, 6'b011011, 1'b0);
    @(negedge clk);
    check("divu_off_stall", int'(bus.stall), 0);
    dq.push_back('{code: 4'b0011, ill: 1'b1});
    tick();
    idle();
    repeat (8) tick();
`endif

    idle();
    repeat (3) tick();
    check("dec_queue_empty", dq.size(), 0);
    check("md_queue_empty", mq.size(), 0);
    check("hilo_queue_empty", hq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CODE_W, default 4: width of alu_code; legal range 4..8; 4-bit codes zero-extended.
REQ-002 Parameter MUL_LAT, default 4: cycles from md_start to hilo_we for mult/multu; legal range 1..64.
REQ-003 Parameter DIV_LAT, default 33: cycles from md_start to hilo_we for div/divu; legal range 1..64.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 valid  in  1  ID-stage instruction present.
REQ-007 flush  in  1  kill the instruction presented this cycle.
REQ-008 aluop  in  3  main-decoder ALU class.
REQ-009 funct  in  6  instruction bits [5:0].
REQ-010 alu_code  out  CODE_W  registered ALU operation for EX.
REQ-011 out_valid  out  1  alu_code belongs to a live instruction.
REQ-012 illegal  out  1  registered; live R-type with undecodable funct.
REQ-013 stall  out  1  combinational; hold IF/ID, insert bubble.
REQ-014 md_start  out  1  one-cycle pulse launching the mult/div datapath.
REQ-015 md_op  out  2  registered with md_start: 00 mult, 01 multu, 10 div, 11 divu.
REQ-016 md_busy  out  1  sequencer not IDLE.
REQ-017 hilo_we  out  1  one-cycle pulse: write HI/LO from mult/div result.

Function
REQ-018 R-type (aluop 000) SHALL decode: sll/sllv 0000, srl/srlv 0001, sra/srav 0010, addu/jalr(001001) 0011, subu 1010, and 0101, or 0110, xor 0111, nor 1000, slt 0100.
REQ-019 aluop 001..111 SHALL decode: 0011, 0101, 0110, 0111, 0000, 0100, 1001 (lui).
REQ-020 mult/multu/div/divu (011000..011011) and mfhi/mthi/mflo/mtlo (010000..010011) SHALL decode alu_code 0011 and illegal 0.
REQ-021 Any other R-type funct SHALL produce alu_code 0011 and illegal 1; no latched or X outputs.
REQ-022 Accept = valid & !flush & !stall; on accept, alu_code/illegal/out_valid load decoded values next edge (latency 1).
REQ-023 No accept: out_valid 0, illegal 0, alu_code holds.
REQ-024 FSM states IDLE, RUN, DONE.
REQ-025 IDLE: accepted mult/div -> md_start 1 and md_op set on next edge, counter loaded with LAT-1, enter RUN.
REQ-026 RUN: counter decrements each cycle; at 0 -> DONE.
REQ-027 DONE: hilo_we 1 for exactly that cycle; next state IDLE.
REQ-028 LAT=1: RUN lasts one cycle; hilo_we exactly 1 cycle after the md_start cycle.
REQ-029 stall = valid & !flush & (state != IDLE) & funct in {mult/div group, mfhi/mthi/mflo/mtlo} & aluop 000.
REQ-030 Non-HI/LO instructions SHALL be accepted while md_busy (no stall).
REQ-031 flush and a mult/div on the same cycle: flush wins, no md_start.
REQ-032 flush SHALL NOT abort a running operation.
REQ-033 md_busy = (state != IDLE); counter width = clog2(max(MUL_LAT, DIV_LAT)).

Reset
REQ-034 rst low at an edge: state IDLE, counter 0, alu_code 0, out_valid 0, illegal 0, md_start 0, md_op 00, hilo_we 0.
REQ-035 Reset mid-operation SHALL abandon it; no hilo_we is issued afterwards.

Configuration
REQ-036 Macro ALU_CTRL_SEQ_DIV_EN defined: div/divu sequenced with DIV_LAT per REQ-025..027.
REQ-037 Macro undefined: div/divu decode illegal 1, no md_start, no stall; DIV_LAT ignored; mult/multu unchanged.

Verification
REQ-038 Reset then aluop 000, funct 100011, valid -> next cycle alu_code 1010, out_valid 1, illegal 0.
REQ-039 aluop 000, funct 111111, valid -> next cycle illegal 1, alu_code 0011, out_valid 1.
REQ-040 mult at cycle 0, MUL_LAT 4 -> md_start cycle 1, md_op 00, hilo_we cycle 5, md_busy cycles 1..5.
REQ-041 mflo presented during busy -> stall 1 until DONE passes; accepted on the first cycle IDLE; addu during busy accepted without stall.
REQ-042 div issued, rst low at cycle 10 -> md_busy 0 at cycle 11, hilo_we never asserted; without ALU_CTRL_SEQ_DIV_EN, div -> illegal 1, no md_start.
REQ-043 mult plus flush in the same cycle -> no md_start, out_valid 0 next cycle.
